spi_req_arbiter: RTL and testbench

SPI_REQ_ARBITER -- requirements
Module: spi_req_arbiter

---
 rtl/spi_arb_pkg.sv | 15 +
 rtl/spi_req_arbiter_rr_pick.sv | 34 +++
 rtl/spi_req_arbiter.sv | 133 +++++++++++++
 tb/tb_spi_req_arbiter.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_arb_pkg.sv
// Shared types and default parameters for the SPI request arbiter.
package spi_arb_pkg;

  localparam int NUM_REQ_DEF = 4;
  localparam int TIMEOUT_DEF = 15;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LAUNCH    = 3'd1,
    ST_WAIT_BUSY = 3'd2,
    ST_XFER      = 3'd3,
    ST_DONE      = 3'd4
  } arb_state_e;

endpackage

// File: rtl/spi_req_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, modulo N.
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          any
);

  // Scan from ptr upward with wrap; the first hit wins.
  always_comb begin
    int            c;
    logic [IW-1:0] c_idx;
    c     = 0;
    c_idx = '0;
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    for (int k = 0; k < N; k++) begin
      c = int'(ptr) + k;
      if (c >= N) c = c - N;
      c_idx = IW'(c);
      if (!any && req[c_idx]) begin
        any          = 1'b1;
        grant[c_idx] = 1'b1;
        idx          = c_idx;
      end
    end
  end

endmodule

// File: rtl/spi_req_arbiter.sv
// Round-robin arbiter sharing one SPI master between NUM_REQ requesters.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// IDLE      | waiting for a request while the master is idle
// LAUNCH    | start pulse to the master with the owner's byte
// WAIT_BUSY | waiting for the master to raise busy; bounded by TIMEOUT
// XFER      | master busy; unbounded wait for busy to fall
// DONE      | one-cycle response to the owner, cs released, pointer moved
module spi_req_arbiter
  import spi_arb_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [NUM_REQ*8-1:0] req_data,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic [NUM_REQ-1:0]   rsp_valid,
  output logic [7:0]           rsp_data,
  output logic                 rsp_err,
  output logic [NUM_REQ-1:0]   cs_sel,
  output logic [7:0]           m_tx_data,
  output logic                 m_tx_valid,
  input  logic                 m_busy,
  input  logic [7:0]           m_rx_data
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(TIMEOUT + 1);

  arb_state_e          state;
  logic [IW-1:0]       rr_ptr;
  logic [IW-1:0]       owner;
  logic [CW-1:0]       cnt;
  logic [NUM_REQ-1:0]  pick_grant;
  logic [IW-1:0]       pick_idx;
  logic                pick_any;
  logic [7:0]          pick_byte;
  logic [NUM_REQ-1:0]  owner_oh;
  logic                accept;

  rr_pick #(.N(NUM_REQ), .IW(IW)) u_pick (
    .req   (req_valid),
    .ptr   (rr_ptr),
    .grant (pick_grant),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  // A busy master in IDLE masks every grant.
  assign req_ready = (state == ST_IDLE && !m_busy) ? pick_grant : '0;
  assign accept    = (state == ST_IDLE) && !m_busy && pick_any;

  // TX byte of the currently picked requester.
  always_comb begin
    pick_byte = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick_grant[i]) pick_byte = req_data[i*8 +: 8];
    end
  end

  // One-hot form of the latched owner for response and chip-select.
  always_comb begin
    owner_oh        = '0;
    owner_oh[owner] = 1'b1;
  end

  // Main sequencer; all interface outputs are registered here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      rr_ptr     <= '0;
      owner      <= '0;
      cnt        <= '0;
      cs_sel     <= '0;
      m_tx_valid <= 1'b0;
      m_tx_data  <= 8'h00;
      rsp_valid  <= '0;
      rsp_data   <= 8'h00;
      rsp_err    <= 1'b0;
    end else begin
      m_tx_valid <= 1'b0;
      rsp_valid  <= '0;
      rsp_err    <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            owner      <= pick_idx;
            m_tx_data  <= pick_byte;
            cs_sel     <= pick_grant;
            m_tx_valid <= 1'b1;
            state      <= ST_LAUNCH;
          end
        end
        ST_LAUNCH: begin
          cnt   <= '0;
          state <= ST_WAIT_BUSY;
        end
        ST_WAIT_BUSY: begin
          if (m_busy) begin
            state <= ST_XFER;
          end else begin
            cnt <= cnt + 1'b1;
            // Counter is about to reach TIMEOUT: give up with an error response.
            if (cnt == CW'(TIMEOUT - 1)) begin
              rsp_valid <= owner_oh;
              rsp_data  <= 8'h00;
              rsp_err   <= 1'b1;
              state     <= ST_DONE;
            end
          end
        end
        ST_XFER: begin
          if (!m_busy) begin
            rsp_valid <= owner_oh;
            rsp_data  <= m_rx_data;
            state     <= ST_DONE;
          end
        end
        ST_DONE: begin
          cs_sel <= '0;
          rr_ptr <= (owner == IW'(NUM_REQ - 1)) ? '0 : owner + 1'b1;
          state  <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_req_arbiter.sv
// Scoreboard bench for spi_req_arbiter with a behavioural SPI master stand-in.
module tb_spi_req_arbiter;

  localparam int N  = 4;
  localparam int TO = 15;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   req_valid = '0;
  logic [N*8-1:0] req_data = '0;
  logic [N-1:0]   req_ready;
  logic [N-1:0]   rsp_valid;
  logic [7:0]     rsp_data;
  logic           rsp_err;
  logic [N-1:0]   cs_sel;
  logic [7:0]     m_tx_data;
  logic           m_tx_valid;
  logic           m_busy;
  logic [7:0]     m_rx_data = 8'h00;
  logic           sl_busy = 1'b0;
  logic           lock_busy = 1'b0;

  assign m_busy = sl_busy | lock_busy;

  spi_req_arbiter #(.NUM_REQ(N), .TIMEOUT(TO)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .rsp_valid  (rsp_valid),
    .rsp_data   (rsp_data),
    .rsp_err    (rsp_err),
    .cs_sel     (cs_sel),
    .m_tx_data  (m_tx_data),
    .m_tx_valid (m_tx_valid),
    .m_busy     (m_busy),
    .m_rx_data  (m_rx_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] oh;
    logic [7:0]   data;
    logic         err;
    int           cyc;
  } rsp_exp_t;

  typedef struct {
    logic [N-1:0] oh;
    logic [7:0]   data;
  } tx_exp_t;

  rsp_exp_t     rspq[$];
  tx_exp_t      txq[$];
  logic [N-1:0] gq[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rsp_cnt = 0;
  int tmo_cnt = 0;
  bit done_req = 1'b0;
  bit final_done = 1'b0;
  bit prev_tx = 1'b0;

  bit         sl_timeout = 1'b0;
  int         sl_delay = 1;
  int         sl_len = 1;
  logic [7:0] sl_rx = 8'h00;

  int ptr = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h cycle=%0d", name, got, exp, cyc);
    end
  endtask

  // Reference grant rule: first requesting index at or after the pointer, wrapping.
  function automatic int pick(input logic [N-1:0] m, input int p);
    for (int k = 0; k < N; k++) begin
      if (m[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // SPI master stand-in: raises busy sl_delay edges after the launch, for sl_len edges.
  initial forever begin
    @(negedge clk);
    if (!rst && m_tx_valid && !sl_timeout) begin
      repeat (sl_delay) @(posedge clk);
      #1 sl_busy = 1'b1;
      m_rx_data = sl_rx;
      repeat (sl_len) @(posedge clk);
      #1 sl_busy = 1'b0;
    end
  end

  // Monitor: pops expectations whenever the DUT presents grant, launch or response.
  initial begin
    logic [N-1:0] ge;
    rsp_exp_t     re;
    tx_exp_t      te;
    forever begin
      @(negedge clk);
      if (rst) begin
        chk("rst_req_ready", 32'(req_ready), 0);
        chk("rst_rsp_valid", 32'(rsp_valid), 0);
        chk("rst_cs_sel", 32'(cs_sel), 0);
        chk("rst_m_tx_valid", 32'(m_tx_valid), 0);
        chk("rst_m_tx_data", 32'(m_tx_data), 0);
        chk("rst_rsp_data", 32'(rsp_data), 0);
        chk("rst_rsp_err", 32'(rsp_err), 0);
      end else begin
        if (lock_busy) chk("busy_lock_ready", 32'(req_ready), 0);
        if (req_ready != '0) begin
          if (gq.size() == 0) chk("grant_unexpected", 32'(req_ready), 0);
          else begin
            ge = gq.pop_front();
            chk("grant", 32'(req_ready), 32'(ge));
          end
        end
        if (m_tx_valid) begin
          chk("tx_pulse_width", 32'(prev_tx), 0);
          if (txq.size() == 0) chk("tx_unexpected", 32'(m_tx_valid), 0);
          else begin
            te = txq.pop_front();
            chk("tx_data", 32'(m_tx_data), 32'(te.data));
            chk("cs_sel_launch", 32'(cs_sel), 32'(te.oh));
          end
        end
        if (rsp_valid != '0) begin
          if (rspq.size() == 0) chk("rsp_unexpected", 32'(rsp_valid), 0);
          else begin
            re = rspq.pop_front();
            chk("rsp_valid", 32'(rsp_valid), 32'(re.oh));
            chk("rsp_data", 32'(rsp_data), 32'(re.data));
            chk("rsp_err", 32'(rsp_err), 32'(re.err));
            chk("rsp_cycle", 32'(cyc), 32'(re.cyc));
            chk("cs_sel_done", 32'(cs_sel), 32'(re.oh));
          end
          rsp_cnt++;
        end else begin
          chk("rsp_err_idle", 32'(rsp_err), 0);
        end
      end
      prev_tx = m_tx_valid;
      if (done_req && !final_done) begin
        chk("wait_bounds", 32'(tmo_cnt), 0);
        chk("rspq_drained", 32'(rspq.size()), 0);
        chk("gq_drained", 32'(gq.size()), 0);
        chk("txq_drained", 32'(txq.size()), 0);
        final_done = 1'b1;
      end
    end
  end

  // One transaction: predict owner and response, drive request, wait for the outcome.
  task automatic run_txn(input logic [N-1:0] mask, input bit hold, input bit tmo,
                         input int dly, input int len, input logic [7:0] txb,
                         input logic [7:0] rxb, input bit do_rst);
    int             own;
    int             a;
    int             start_cnt;
    bit             got;
    logic [N*8-1:0] d;
    logic [N-1:0]   oh;
    rsp_exp_t       re;
    tx_exp_t        te;
    own = pick(mask, ptr);
    for (int i = 0; i < N; i++) d[i*8 +: 8] = 8'($urandom);
    d[own*8 +: 8] = txb;
    oh = '0;
    oh[own] = 1'b1;
    sl_timeout = tmo;
    sl_delay = dly;
    sl_len = len;
    sl_rx = rxb;
    gq.push_back(oh);
    te.oh = oh;
    te.data = txb;
    txq.push_back(te);
    req_data = d;
    req_valid = mask;
    got = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (req_ready != '0) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      $display("FAIL wait_ready got=none required=grant mask=%b", mask);
      tmo_cnt++;
      gq.delete();
      txq.delete();
      req_valid = '0;
      return;
    end
    a = cyc;
    if (!do_rst) begin
      re.oh = oh;
      re.data = tmo ? 8'h00 : rxb;
      re.err = tmo;
      re.cyc = a + (tmo ? TO + 2 : dly + len + 2);
      rspq.push_back(re);
    end
    start_cnt = rsp_cnt;
    @(posedge clk);
    #1;
    if (!hold) req_valid = '0;
    ptr = (own + 1) % N;
    if (do_rst) begin
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      ptr = 0;
      repeat (30) @(posedge clk);
      #1;
      return;
    end
    got = 1'b0;
    for (int k = 0; k < 60; k++) begin
      @(posedge clk);
      if (rsp_cnt > start_cnt) begin
        got = 1'b1;
        break;
      end
    end
    #1;
    if (!got) begin
      $display("FAIL wait_rsp got=none required=rsp_valid owner=%0d", own);
      tmo_cnt++;
    end
  endtask

  initial begin
    logic [N-1:0] m;
    bit           t;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // All four requesting continuously from reset: 0,1,2,3,0 at minimum latency.
    for (int i = 0; i < 5; i++)
      run_txn(4'b1111, (i < 4), 1'b0, 1, 1, 8'($urandom), 8'($urandom), 1'b0);

    // Single request with fixed bytes and an 8-cycle busy window.
    run_txn(4'b0001, 1'b0, 1'b0, 1, 8, 8'hA5, 8'h3C, 1'b0);

    // Wrap and skip: pointer at 3 with requests 0 and 2.
    run_txn(4'b0100, 1'b0, 1'b0, 2, 1, 8'($urandom), 8'($urandom), 1'b0);
    run_txn(4'b0101, 1'b0, 1'b0, 1, 2, 8'($urandom), 8'($urandom), 1'b0);
    run_txn(4'b0101, 1'b0, 1'b0, 1, 1, 8'($urandom), 8'($urandom), 1'b0);

    // Master never responds.
    run_txn(4'b1010, 1'b0, 1'b1, 1, 1, 8'($urandom), 8'($urandom), 1'b0);

    // Busy master in IDLE blocks the grant until it drops.
    lock_busy = 1'b1;
    req_valid = 4'b0010;
    repeat (6) @(posedge clk);
    #1 lock_busy = 1'b0;
    req_valid = '0;
    run_txn(4'b0010, 1'b0, 1'b0, 1, 1, 8'($urandom), 8'($urandom), 1'b0);

    for (int i = 0; i < 25; i++) begin
      m = 4'($urandom_range(1, 15));
      t = ($urandom_range(0, 4) == 0);
      run_txn(m, 1'b0, t, $urandom_range(1, 4), $urandom_range(1, 5),
              8'($urandom), 8'($urandom), 1'b0);
    end

    // Reset in the middle of a transfer, then the pointer restarts at 0.
    run_txn(4'($urandom_range(1, 15)), 1'b0, 1'b0, 1, 20, 8'($urandom), 8'($urandom), 1'b1);
    run_txn(4'b1111, 1'b0, 1'b0, 1, 1, 8'($urandom), 8'($urandom), 1'b0);
    run_txn(4'b1110, 1'b0, 1'b0, 3, 2, 8'($urandom), 8'($urandom), 1'b0);

    done_req = 1'b1;
    for (int k = 0; k < 10 && !final_done; k++) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
